// File: rtl/detect_burst_multi_if.sv
// Burst-detector bus bundle: the input address FIFO pop side plus the address and
// burst-length output FIFO push sides. master = detector, slave = FIFO/environment.
interface detect_burst_multi_if #(
    parameter int AddrWidth     = 64,
    parameter int BurstLenWidth = 8,
    parameter int NumLenPorts   = 2
) ();
    logic [AddrWidth-1:0]                 addr_dout;
    logic                                 addr_empty_n;
    logic                                 addr_read;
    logic [BurstLenWidth+AddrWidth-1:0]   addr_din;
    logic                                 addr_full_n;
    logic                                 addr_write;
    logic [NumLenPorts*BurstLenWidth-1:0] burst_len_din;
    logic [NumLenPorts-1:0]               burst_len_full_n;
    logic [NumLenPorts-1:0]               burst_len_write;

    // Handshake: a pop happens in every cycle addr_read is high (only while
    // addr_empty_n); a push happens on every cycle *_write is high, and all output
    // pushes fire together only when every output FIFO reports not-full.
    modport master (
        input  addr_dout, addr_empty_n, addr_full_n, burst_len_full_n,
        output addr_read, addr_din, addr_write, burst_len_din, burst_len_write
    );

    modport slave (
        output addr_dout, addr_empty_n, addr_full_n, burst_len_full_n,
        input  addr_read, addr_din, addr_write, burst_len_din, burst_len_write
    );
endinterface

// File: rtl/detect_burst_multi.sv
// Coalesces a stream of beat addresses into {len-1, base} bursts that never cross a
// 2^BoundaryLog-byte page, with idle timeout, flush, a registered output stage and a counter.
module detect_burst_multi #(
    parameter int AddrWidth         = 64,
    parameter int DataWidthBytesLog = 6,
    parameter int WaitTimeWidth     = 4,
    parameter int BurstLenWidth     = 8,
    parameter int NumLenPorts       = 2,
    parameter int BoundaryLog       = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WaitTimeWidth-1:0] max_wait_time,
    input  logic [BurstLenWidth-1:0] max_burst_len,
    input  logic                     flush,
    detect_burst_multi_if.master     bus,
    output logic [31:0]              burst_count,
    output logic                     state_o
);
    localparam int BeatW = AddrWidth - DataWidthBytesLog;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [AddrWidth-1:0]     base_q, base_d;
    logic [BurstLenWidth-1:0] len_q, len_d;
    logic [WaitTimeWidth-1:0] wait_q, wait_d;
    logic                     out_pending_q, out_pending_d;
    logic [AddrWidth-1:0]     out_addr_q, out_addr_d;
    logic [BurstLenWidth-1:0] out_len_q, out_len_d;
    logic [31:0]              burst_count_q, burst_count_d;

    logic             all_ready, stall, rd, wr, emit;
    logic             contig, room, same_page, merge;
    logic [BeatW-1:0] beat_next;

    assign all_ready = bus.addr_full_n & (&bus.burst_len_full_n);
    assign stall     = out_pending_q & ~all_ready;
    // Reset also gates the pop so the input FIFO is not drained while held in reset.
    assign rd        = bus.addr_empty_n & ~stall & rst_n;
    assign wr        = out_pending_q & all_ready;

    assign bus.addr_read       = rd;
    assign bus.addr_write      = wr;
    assign bus.burst_len_write = {NumLenPorts{wr}};
    assign bus.addr_din        = {out_len_q, out_addr_q};
    assign bus.burst_len_din   = {NumLenPorts{out_len_q}};
    assign burst_count         = burst_count_q;
    assign state_o             = state_q;

    // Contiguity works on beat addresses, so byte-offset bits of base are ignored.
    assign beat_next = base_q[AddrWidth-1:DataWidthBytesLog] + BeatW'(len_q) + BeatW'(1);
    assign contig    = (bus.addr_dout[AddrWidth-1:DataWidthBytesLog] == beat_next);
    assign room      = (len_q < max_burst_len);

    generate
        if (BoundaryLog < AddrWidth) begin : g_page
            assign same_page = (bus.addr_dout[AddrWidth-1:BoundaryLog] == base_q[AddrWidth-1:BoundaryLog]);
        end else begin : g_no_page
            assign same_page = 1'b1;
        end
    endgenerate

    assign merge = contig & room & same_page;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        wait_d  = wait_q;
        emit    = 1'b0;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (rd) begin
                        base_d  = bus.addr_dout;
                        len_d   = '0;
                        wait_d  = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (rd) begin
                        if (merge) begin
                            len_d = len_q + BurstLenWidth'(1);
                        end else begin
                            emit   = 1'b1;
                            base_d = bus.addr_dout;
                            len_d  = '0;
                        end
                        wait_d = '0;
                    end else if (flush || (wait_q == max_wait_time)) begin
                        emit    = 1'b1;
                        wait_d  = '0;
                        state_d = IDLE;
                    end else begin
                        wait_d = wait_q + WaitTimeWidth'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Emit can only happen when not stalled, i.e. the output slot is free or drains this cycle.
    always_comb begin
        out_pending_d = emit | (out_pending_q & ~wr);
        out_addr_d    = emit ? base_q : out_addr_q;
        out_len_d     = emit ? len_q : out_len_q;
        burst_count_d = burst_count_q;
        if (wr && (burst_count_q != 32'hFFFF_FFFF)) begin
            burst_count_d = burst_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            len_q         <= '0;
            wait_q        <= '0;
            out_pending_q <= 1'b0;
            out_addr_q    <= '0;
            out_len_q     <= '0;
            burst_count_q <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            len_q         <= len_d;
            wait_q        <= wait_d;
            out_pending_q <= out_pending_d;
            out_addr_q    <= out_addr_d;
            out_len_q     <= out_len_d;
            burst_count_q <= burst_count_d;
        end
    end
endmodule

// File: tb/tb_detect_burst_multi.sv
// Directed bench for detect_burst_multi: a table of address streams with expected bursts,
// plus hand-written latency, backpressure, flush and reset sequences.
module tb_detect_burst_multi;
    localparam int AW = 64;
    localparam int LW = 8;
    localparam int NP = 2;
    localparam int DW = LW + AW;
    localparam int NV = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  max_wait_time;
    logic [7:0]  max_burst_len;
    logic        flush;
    logic [31:0] burst_count;
    logic        state_o;

    always #5 clk = ~clk;

    detect_burst_multi_if #(.AddrWidth(AW), .BurstLenWidth(LW), .NumLenPorts(NP)) bus ();

    detect_burst_multi dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .max_wait_time (max_wait_time),
        .max_burst_len (max_burst_len),
        .flush         (flush),
        .bus           (bus),
        .burst_count   (burst_count),
        .state_o       (state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_bursts = 0;

    // Source FIFO model: initial block pushes, DUT pops.
    logic [AW-1:0] src_mem [0:63];
    int src_wr = 0;
    int src_rd = 0;
    assign bus.addr_dout    = src_mem[src_rd[5:0]];
    assign bus.addr_empty_n = (src_rd != src_wr);
    always @(posedge clk) if (bus.addr_read) src_rd <= src_rd + 1;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Sink monitor: every output write must hit all ports together with the same len.
    always @(negedge clk) begin
        if (rst_n && bus.addr_write) begin
            got_q.push_back(bus.addr_din);
            check("len_ports", DW'({bus.burst_len_write, bus.burst_len_din}),
                  DW'({2'b11, {2{bus.addr_din[DW-1:AW]}}}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] a);
        src_mem[src_wr[5:0]] = a;
        src_wr++;
    endtask

    task automatic expect_burst(input logic [LW-1:0] len, input logic [AW-1:0] a);
        exp_q.push_back({len, a});
        exp_bursts++;
    endtask

    task automatic compare_sb(input string name);
        check({name, "_cnt"}, DW'(got_q.size()), DW'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({name, "_burst"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        check({name, "_count"}, DW'(burst_count), DW'(exp_bursts));
    endtask

    typedef struct packed {
        logic [7:0]             mbl;
        logic [3:0]             mwt;
        logic [2:0]             n_in;
        logic [3:0][AW-1:0]     a;
        logic [2:0]             n_exp;
        logic [3:0][LW-1:0]     el;
        logic [3:0][AW-1:0]     ea;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic [7:0] mbl, input logic [3:0] mwt,
                                input logic [2:0] n_in, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic [AW-1:0] a3, input logic [2:0] n_exp,
                                input logic [LW-1:0] l0, input logic [AW-1:0] e0,
                                input logic [LW-1:0] l1, input logic [AW-1:0] e1,
                                input logic [LW-1:0] l2, input logic [AW-1:0] e2,
                                input logic [LW-1:0] l3, input logic [AW-1:0] e3);
        vec_t v;
        v.mbl = mbl; v.mwt = mwt; v.n_in = n_in; v.n_exp = n_exp;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.el[0] = l0; v.el[1] = l1; v.el[2] = l2; v.el[3] = l3;
        v.ea[0] = e0; v.ea[1] = e1; v.ea[2] = e2; v.ea[3] = e3;
        return v;
    endfunction

    int lat;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 4 contiguous beats -> one burst
        vecs[0] = mk(255, 3, 4, 'h1000, 'h1040, 'h1080, 'h10C0, 1, 3, 'h1000, 0, 0, 0, 0, 0, 0);
        // contiguous beats across a 4 KiB page: never merged
        vecs[1] = mk(255, 3, 2, 'h0FC0, 'h1000, 0, 0, 2, 0, 'h0FC0, 0, 'h1000, 0, 0, 0, 0);
        // max_burst_len=1 caps bursts at two beats
        vecs[2] = mk(1, 3, 4, 'h0, 'h40, 'h80, 'hC0, 2, 1, 'h0, 1, 'h80, 0, 0, 0, 0);
        // max_burst_len=0 never merges
        vecs[3] = mk(0, 3, 4, 'h0, 'h40, 'h80, 'hC0, 4, 0, 'h0, 0, 'h40, 0, 'h80, 0, 'hC0);
        // byte-offset bits of base are carried verbatim and ignored for contiguity
        vecs[4] = mk(255, 2, 2, 'h3005, 'h3040, 0, 0, 1, 1, 'h3005, 0, 0, 0, 0, 0, 0);
        // gap of one beat
        vecs[5] = mk(255, 2, 2, 'h5000, 'h5080, 0, 0, 2, 0, 'h5000, 0, 'h5080, 0, 0, 0, 0);
        // wrap at the top of the address space
        vecs[6] = mk(255, 1, 2, 64'hFFFF_FFFF_FFFF_FFC0, 'h0, 0, 0, 2,
                     0, 64'hFFFF_FFFF_FFFF_FFC0, 0, 'h0, 0, 0, 0, 0);
        // descending addresses
        vecs[7] = mk(255, 0, 2, 'h1040, 'h1000, 0, 0, 2, 0, 'h1040, 0, 'h1000, 0, 0, 0, 0);

        max_wait_time        = 4'd3;
        max_burst_len        = 8'd255;
        flush                = 1'b0;
        bus.addr_full_n      = 1'b1;
        bus.burst_len_full_n = 2'b11;

        // Reset state
        tick();
        tick();
        check("rst_count", DW'(burst_count), 0);
        check("rst_din", bus.addr_din, 0);
        check("rst_ctl", DW'({bus.addr_read, bus.addr_write, bus.burst_len_write, state_o}), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            max_burst_len = vecs[i].mbl;
            max_wait_time = vecs[i].mwt;
            for (int j = 0; j < int'(vecs[i].n_in); j++) push(vecs[i].a[j]);
            for (int j = 0; j < int'(vecs[i].n_exp); j++) expect_burst(vecs[i].el[j], vecs[i].ea[j]);
            repeat (int'(vecs[i].n_in) + int'(vecs[i].mwt) + 10) tick();
            compare_sb($sformatf("vec%0d", i));
        end

        // Latency of a lone address: write on cycle t+2+max_wait_time
        max_burst_len = 8'd255;
        max_wait_time = 4'd3;
        push('h7000);
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) check("lat_read", DW'(bus.addr_read), 1);
            if (bus.addr_write) begin
                lat = k;
                break;
            end
        end
        check("lat_cycles", DW'(lat), 5);
        expect_burst(0, 'h7000);
        repeat (6) tick();
        compare_sb("lat");

        // Backpressure on one length channel
        max_wait_time = 4'd0;
        bus.burst_len_full_n = 2'b01;
        push('h8000);
        repeat (5) tick();
        @(negedge clk);
        check("bp_hold", DW'({bus.addr_write, bus.burst_len_write}), 0);
        push('h9000);
        #1;
        check("bp_noread", DW'(bus.addr_read), 0);
        tick();
        bus.burst_len_full_n = 2'b11;
        @(negedge clk);
        check("bp_release", DW'({bus.addr_write, bus.burst_len_write}), DW'(3'b111));
        check("bp_data", bus.addr_din, {8'd0, 64'h8000});
        @(negedge clk);
        check("bp_single", DW'({bus.addr_write, bus.burst_len_write}), 0);
        expect_burst(0, 'h8000);
        expect_burst(0, 'h9000);
        repeat (6) tick();
        compare_sb("bp");

        // Flush raised alongside the second read closes the burst long before the timeout
        max_wait_time = 4'd15;
        push('h2000);
        push('h2040);
        tick();
        flush = 1'b1;
        lat = -1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (bus.addr_write) begin
                lat = k;
                break;
            end
        end
        check("flush_cycles", DW'(lat), 2);
        check("flush_data", bus.addr_din, {8'd1, 64'h2000});
        check("flush_idle", DW'(state_o), 0);
        tick();
        flush = 1'b0;
        expect_burst(1, 'h2000);
        repeat (4) tick();
        compare_sb("flush");

        // Reset in the middle of a len=5 burst
        for (int j = 0; j < 6; j++) push(64'hA000 + 64'(j) * 64'h40);
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ctl", DW'({bus.addr_read, bus.addr_write, bus.burst_len_write, state_o}), 0);
        check("mrst_count", DW'(burst_count), 0);
        check("mrst_din", bus.addr_din, 0);
        push('hB000);
        #1;
        check("mrst_noread", DW'(bus.addr_read), 0);
        exp_bursts = 0;
        max_wait_time = 4'd1;
        tick();
        rst_n = 1'b1;
        expect_burst(0, 'hB000);
        repeat (8) tick();
        compare_sb("mrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
